// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read path: FSM states, AXI encodings and
// the 4 KB page size that no AXI burst may cross.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        STATUS
    } dma_state_e;

    localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;
    localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT     = 3'b000;
    localparam int unsigned PAGE_BYTES          = 4096;

endpackage

// File: rtl/dma_skid_buffer.sv
// Two-entry valid/ready buffer. Both s_ready and m_valid come straight from
// registers, so the downstream ready never reaches the upstream ready.
module dma_skid_buffer #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             empty
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign s_ready = (count_q != 2'd2);
    assign m_valid = (count_q != 2'd0);
    assign m_data  = head_q;
    assign empty   = (count_q == 2'd0);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // head_q is always the oldest entry; tail_q only holds data when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= s_data;
                    end else begin
                        tail_q <= s_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= s_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= s_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mm2s_burst_reader.sv
// Memory-to-stream reader: splits a command into 4 KB-safe AXI INCR bursts,
// one outstanding at a time, and forwards R beats to an AXI-Stream output.
module mm2s_burst_reader
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] m_mm2s_axi_araddr,
    output logic [7:0]            m_mm2s_axi_arlen,
    output logic                  m_mm2s_axi_arvalid,
    input  logic                  m_mm2s_axi_arready,
    output logic [2:0]            m_mm2s_axi_arsize,
    output logic [1:0]            m_mm2s_axi_arburst,
    output logic [3:0]            m_mm2s_axi_arcache,
    output logic [2:0]            m_mm2s_axi_arprot,
    input  logic [DATA_WIDTH-1:0] m_mm2s_axi_rdata,
    input  logic [1:0]            m_mm2s_axi_rresp,
    input  logic                  m_mm2s_axi_rlast,
    input  logic                  m_mm2s_axi_rvalid,
    output logic                  m_mm2s_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  sts_valid,
    output logic                  sts_error,
    input  logic                  sts_ready
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BEAT_BYTES - 1);

    dma_state_e            state_q;
    dma_state_e            state_d;
    logic                  rst_done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [8:0]            burst_beats_q;
    logic [8:0]            beat_cnt_q;
    logic                  err_q;
    logic                  drain_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;

    logic                  cmd_fire;
    logic                  ar_fire;
    logic                  beat_fire;
    logic                  last_of_burst;
    logic                  burst_end;
    logic                  final_beat;
    logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [LEN_WIDTH-1:0]  remaining_next;
    logic [ADDR_WIDTH-1:0] plan_addr;
    logic [LEN_WIDTH-1:0]  plan_rem;
    logic [12:0]           page_room;
    logic [8:0]            plan_beats;

    logic                  skid_s_ready;
    logic                  skid_m_valid;
    logic [DATA_WIDTH:0]   skid_m_data;
    logic                  skid_empty;

    assign cmd_fire         = cmd_valid && cmd_ready;
    assign ar_fire          = m_mm2s_axi_arvalid && m_mm2s_axi_arready;
    assign beat_fire        = m_mm2s_axi_rvalid && m_mm2s_axi_rready;
    assign last_of_burst    = (beat_cnt_q == (burst_beats_q - 9'd1));
    assign burst_end        = beat_fire && last_of_burst;
    assign cmd_addr_aligned = cmd_addr & ~BEAT_MASK;
    assign addr_next        = addr_q + (ADDR_WIDTH'(burst_beats_q) << BEAT_SHIFT);
    assign remaining_next   = remaining_q - LEN_WIDTH'(burst_beats_q);
    assign final_beat       = last_of_burst && (remaining_next == '0);

    // Bursts are sized either from a fresh command or from the post-burst position
    assign plan_addr = (state_q == IDLE) ? cmd_addr_aligned : addr_next;
    assign plan_rem  = (state_q == IDLE) ? cmd_len : remaining_next;
    assign page_room = (13'(PAGE_BYTES) - {1'b0, plan_addr[11:0]}) >> BEAT_SHIFT;

    always_comb begin
        plan_beats = 9'(MAX_BURST);
        if (page_room < 13'(plan_beats)) begin
            plan_beats = 9'(page_room);
        end
        if (32'(plan_rem) < 32'(plan_beats)) begin
            plan_beats = 9'(plan_rem);
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_len == '0) ? STATUS : ADDR;
                end
            end
            ADDR: begin
                if (ar_fire) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (burst_end && (remaining_next != '0)) begin
                    state_d = ADDR;
                end else if (drain_q && skid_empty) begin
                    state_d = STATUS;
                end
            end
            STATUS: begin
                if (sts_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // drain_q stops further R acceptance once the command's last beat is in the buffer
    always_comb begin
        cmd_ready          = (state_q == IDLE) && rst_done_q;
        m_mm2s_axi_arvalid = (state_q == ADDR);
        m_mm2s_axi_rready  = (state_q == DATA) && !drain_q && skid_s_ready;
        sts_valid          = (state_q == STATUS);
        sts_error          = (state_q == STATUS) && err_q;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            err_q         <= 1'b0;
            drain_q       <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
        end else begin
            if (cmd_fire) begin
                addr_q      <= cmd_addr_aligned;
                remaining_q <= cmd_len;
                err_q       <= 1'b0;
                drain_q     <= 1'b0;
                beat_cnt_q  <= '0;
                if (cmd_len != '0) begin
                    burst_beats_q <= plan_beats;
                    araddr_q      <= plan_addr;
                    arlen_q       <= 8'(plan_beats - 9'd1);
                end
            end
            if (beat_fire) begin
                if (m_mm2s_axi_rresp != AXI_RESP_OKAY) begin
                    err_q <= 1'b1;
                end
                // Our own beat count closes the burst; rlast is only cross-checked
                if (last_of_burst) begin
                    if (!m_mm2s_axi_rlast) begin
                        err_q <= 1'b1;
                    end
                    beat_cnt_q  <= '0;
                    addr_q      <= addr_next;
                    remaining_q <= remaining_next;
                    if (remaining_next != '0) begin
                        burst_beats_q <= plan_beats;
                        araddr_q      <= plan_addr;
                        arlen_q       <= 8'(plan_beats - 9'd1);
                    end else begin
                        drain_q <= 1'b1;
                    end
                end else begin
                    if (m_mm2s_axi_rlast) begin
                        err_q <= 1'b1;
                    end
                    beat_cnt_q <= beat_cnt_q + 9'd1;
                end
            end
        end
    end

    assign m_mm2s_axi_araddr  = araddr_q;
    assign m_mm2s_axi_arlen   = arlen_q;
    assign m_mm2s_axi_arsize  = 3'(BEAT_SHIFT);
    assign m_mm2s_axi_arburst = AXI_BURST_INCR;
    assign m_mm2s_axi_arcache = AXI_CACHE_MODIFIABLE;
    assign m_mm2s_axi_arprot  = AXI_PROT_DEFAULT;

    dma_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (m_axi_aclk),
        .rst_n   (m_axi_aresetn),
        .s_valid (beat_fire),
        .s_ready (skid_s_ready),
        .s_data  ({final_beat, m_mm2s_axi_rdata}),
        .m_valid (skid_m_valid),
        .m_ready (m_axis_tready),
        .m_data  (skid_m_data),
        .empty   (skid_empty)
    );

    assign m_axis_tvalid = skid_m_valid;
    assign m_axis_tdata  = skid_m_data[DATA_WIDTH-1:0];
    assign m_axis_tlast  = skid_m_valid && skid_m_data[DATA_WIDTH];

endmodule

// File: tb/tb_mm2s_burst_reader.sv
// Scoreboard bench for mm2s_burst_reader: a word-indexed memory model answers
// AR bursts, and monitors compare AR, stream and status against directed vectors.
module tb_mm2s_burst_reader;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        sts_valid;
    logic        sts_error;
    logic        sts_ready;

    beat_t exp_beats[$];
    ar_t   exp_ar[$];
    logic  exp_sts[$];
    ar_t   burst_q[$];

    int   checks = 0;
    int   failures = 0;
    int   sts_count = 0;
    int   ar_count = 0;
    int   beats_seen = 0;
    int   err_word = -1;
    logic tready_pat [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    mm2s_burst_reader #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .MAX_BURST  (16),
        .LEN_WIDTH  (16)
    ) dut (
        .m_axi_aclk         (clk),
        .m_axi_aresetn      (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .m_mm2s_axi_araddr  (araddr),
        .m_mm2s_axi_arlen   (arlen),
        .m_mm2s_axi_arvalid (arvalid),
        .m_mm2s_axi_arready (arready),
        .m_mm2s_axi_arsize  (arsize),
        .m_mm2s_axi_arburst (arburst),
        .m_mm2s_axi_arcache (arcache),
        .m_mm2s_axi_arprot  (arprot),
        .m_mm2s_axi_rdata   (rdata),
        .m_mm2s_axi_rresp   (rresp),
        .m_mm2s_axi_rlast   (rlast),
        .m_mm2s_axi_rvalid  (rvalid),
        .m_mm2s_axi_rready  (rready),
        .m_axis_tdata       (tdata),
        .m_axis_tvalid      (tvalid),
        .m_axis_tlast       (tlast),
        .m_axis_tready      (tready),
        .sts_valid          (sts_valid),
        .sts_error          (sts_error),
        .sts_ready          (sts_ready)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        checkOutput({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        checkOutput({tag, "_rready"}, 64'(rready), 64'd0);
        checkOutput({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        checkOutput({tag, "_tlast"}, 64'(tlast), 64'd0);
        checkOutput({tag, "_sts_valid"}, 64'(sts_valid), 64'd0);
        checkOutput({tag, "_sts_error"}, 64'(sts_error), 64'd0);
        checkOutput({tag, "_araddr"}, 64'(araddr), 64'd0);
        checkOutput({tag, "_arlen"}, 64'(arlen), 64'd0);
    endtask

    task automatic expectAr(input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        exp_ar.push_back(a);
    endtask

    task automatic driveCmd(input logic [31:0] addr, input logic [15:0] len, input string name);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_cmd_accepted"}, 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len,
                                 input logic exp_err, input string name);
        beat_t e;
        int    guard = 0;
        int    sts_before;
        int    base;
        base = int'(addr >> 3);
        for (int i = 0; i < int'(len); i++) begin
            e.data = 64'(base + i);
            e.last = (i == int'(len) - 1);
            exp_beats.push_back(e);
        end
        exp_sts.push_back(exp_err);
        sts_before = sts_count;
        driveCmd(addr, len, name);
        while (sts_count == sts_before && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_status_seen"}, 64'(sts_count != sts_before), 64'd1);
        checkOutput({name, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
        checkOutput({name, "_ars_left"}, 64'(exp_ar.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Memory model: returns the word index of each address, rlast on the requested final beat
    initial begin : slave
        ar_t b;
        int  r_beat;
        int  word;
        bit  r_active;
        r_beat   = 0;
        r_active = 1'b0;
        b        = '0;
        rvalid   = 1'b0;
        rdata    = '0;
        rresp    = 2'b00;
        rlast    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_active = 1'b0;
                burst_q.delete();
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end else begin
                if (!r_active && burst_q.size() > 0) begin
                    b        = burst_q.pop_front();
                    r_active = 1'b1;
                    r_beat   = 0;
                end
                if (r_active) begin
                    word   = int'(b.addr >> 3) + r_beat;
                    rvalid = 1'b1;
                    rdata  = 64'(word);
                    rlast  = (r_beat == int'(b.len));
                    rresp  = (word == err_word) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                    rresp  = 2'b00;
                end
                #1;
                if (rst_n && rvalid && rready) begin
                    r_beat++;
                    if (r_beat > int'(b.len)) begin
                        r_active = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: drives the ready inputs of DUT-output channels and pops the scoreboard
    initial begin : monitor
        beat_t e;
        ar_t   a;
        logic  s;
        int    ar_wait;
        int    sts_wait;
        int    pat_idx;
        int    occ;
        ar_wait   = 0;
        sts_wait  = 0;
        pat_idx   = 0;
        occ       = 0;
        arready   = 1'b0;
        sts_ready = 1'b0;
        tready    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready   = 1'b0;
                sts_ready = 1'b0;
                tready    = 1'b0;
                ar_wait   = 0;
                sts_wait  = 0;
                pat_idx   = 0;
                occ       = 0;
            end else begin
                arready   = arvalid && (ar_wait >= 1);
                ar_wait   = arvalid ? ar_wait + 1 : 0;
                sts_ready = sts_valid && (sts_wait >= 1);
                sts_wait  = sts_valid ? sts_wait + 1 : 0;
                tready    = tready_pat[pat_idx];
                pat_idx   = (pat_idx + 1) % 4;
                #1;
                if (rst_n) begin
                    if (occ == 2) begin
                        checkOutput("rready_when_full", 64'(rready), 64'd0);
                    end
                    if (arvalid && arready) begin
                        ar_count++;
                        if (exp_ar.size() == 0) begin
                            checkOutput("ar_unexpected", 64'd1, 64'd0);
                        end else begin
                            a = exp_ar.pop_front();
                            checkOutput("ar_addr", 64'(araddr), 64'(a.addr));
                            checkOutput("ar_len", 64'(arlen), 64'(a.len));
                        end
                        a.addr = araddr;
                        a.len  = arlen;
                        burst_q.push_back(a);
                    end
                    if (tvalid && tready) begin
                        beats_seen++;
                        if (exp_beats.size() == 0) begin
                            checkOutput("beat_unexpected", 64'd1, 64'd0);
                        end else begin
                            e = exp_beats.pop_front();
                            checkOutput("beat_data", tdata, e.data);
                            checkOutput("beat_last", 64'(tlast), 64'(e.last));
                        end
                    end
                    if (sts_valid && sts_ready) begin
                        sts_count++;
                        if (exp_sts.size() == 0) begin
                            checkOutput("status_unexpected", 64'd1, 64'd0);
                        end else begin
                            s = exp_sts.pop_front();
                            checkOutput("status_error", 64'(sts_error), 64'(s));
                        end
                    end
                    occ = occ + int'(rvalid && rready) - int'(tvalid && tready);
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        int ar_before;
        int beats_before;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        checkOutput("arsize", 64'(arsize), 64'd3);
        checkOutput("arburst", 64'(arburst), 64'd1);
        checkOutput("arcache", 64'(arcache), 64'd3);
        checkOutput("arprot", 64'(arprot), 64'd0);

        $display("[TB] single burst");
        expectAr(32'h0, 8'd3);
        applyStimulus(32'h0, 16'd4, 1'b0, "single");

        $display("[TB] three bursts");
        expectAr(32'h000, 8'd15);
        expectAr(32'h080, 8'd15);
        expectAr(32'h100, 8'd7);
        applyStimulus(32'h0, 16'd40, 1'b0, "multi");

        $display("[TB] 4KB crossing");
        expectAr(32'hFE0, 8'd3);
        expectAr(32'h1000, 8'd3);
        applyStimulus(32'hFE0, 16'd8, 1'b0, "page");

        $display("[TB] unaligned start");
        expectAr(32'h10, 8'd1);
        applyStimulus(32'h13, 16'd2, 1'b0, "unaligned");

        $display("[TB] tready backpressure");
        tready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        expectAr(32'h200, 8'd15);
        applyStimulus(32'h200, 16'd16, 1'b0, "backpressure");
        tready_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

        $display("[TB] slave error response");
        err_word = 2;
        expectAr(32'h0, 8'd3);
        applyStimulus(32'h0, 16'd4, 1'b1, "rresp_err");
        err_word = -1;

        $display("[TB] zero length");
        ar_before = ar_count;
        applyStimulus(32'h100, 16'd0, 1'b0, "zero_len");
        checkOutput("zero_len_no_ar", 64'(ar_count - ar_before), 64'd0);

        $display("[TB] reset during data");
        beats_before = beats_seen;
        exp_beats.delete();
        for (int i = 0; i < 40; i++) begin
            exp_beats.push_back({64'(i), (i == 39)});
        end
        expectAr(32'h000, 8'd15);
        expectAr(32'h080, 8'd15);
        expectAr(32'h100, 8'd7);
        driveCmd(32'h0, 16'd40, "midreset");
        guard = 0;
        while (beats_seen < beats_before + 5 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("midreset_beats_started", 64'(beats_seen >= beats_before + 5), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_beats.delete();
        exp_ar.delete();
        exp_sts.delete();
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_after_midreset", 64'(cmd_ready), 64'd1);

        $display("[TB] command after reset");
        expectAr(32'h40, 8'd3);
        applyStimulus(32'h40, 16'd4, 1'b0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm2s_burst_reader.md
MM2S_BURST_READER -- requirements
Module: mm2s_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: AXI R / stream data width in bits; beat bytes B = DATA_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI byte address width.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per AR burst, range 1..256.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: width of the command beat count.
REQ-005 SHALL have port m_axi_aclk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port m_axi_aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1): command handshake.
REQ-008 SHALL have ports cmd_addr (in, ADDR_WIDTH) and cmd_len (in, LEN_WIDTH): start byte address and total beats.
REQ-009 SHALL have ports m_mm2s_axi_araddr (out, ADDR_WIDTH), m_mm2s_axi_arlen (out, 8), m_mm2s_axi_arvalid (out, 1), m_mm2s_axi_arready (in, 1): AR channel.
REQ-010 SHALL have outputs m_mm2s_axi_arsize (3) = log2(B), m_mm2s_axi_arburst (2) = 2'b01, m_mm2s_axi_arcache (4) = 4'b0011, m_mm2s_axi_arprot (3) = 3'b000, all constant.
REQ-011 SHALL have inputs m_mm2s_axi_rdata (DATA_WIDTH), m_mm2s_axi_rresp (2), m_mm2s_axi_rlast (1), m_mm2s_axi_rvalid (1), and output m_mm2s_axi_rready (1): R channel.
REQ-012 SHALL have outputs m_axis_tdata (DATA_WIDTH), m_axis_tvalid (1), m_axis_tlast (1), and input m_axis_tready (1): output stream.
REQ-013 SHALL have outputs sts_valid (1), sts_error (1), and input sts_ready (1): completion status handshake.

Function
REQ-014 SHALL use FSM states IDLE, ADDR, DATA, STATUS; cmd_ready = 1 only in IDLE.
REQ-015 SHALL, on cmd handshake with cmd_len != 0, latch address (low log2(B) bits forced to 0) and remaining = cmd_len, clear error flag, and go to ADDR.
REQ-016 SHALL, on cmd handshake with cmd_len == 0, go directly to STATUS with sts_error = 0 and issue no AR.
REQ-017 SHALL compute burst beats N = min(remaining, MAX_BURST, (4096 - addr[11:0]) / B) on ADDR entry; arlen = N-1; no burst crosses a 4 KB boundary.
REQ-018 SHALL assert arvalid in ADDR the cycle after entry, holding araddr/arlen stable until arready; on handshake go to DATA.
REQ-019 SHALL allow exactly one outstanding burst; next AR issued only after the current burst's last beat is accepted.
REQ-020 SHALL pass R beats through a 2-entry skid buffer to the stream; rready = 1 only in DATA while the buffer has a free entry; no beat dropped or duplicated under any tready pattern.
REQ-021 SHALL count beats per burst; beat N ends the burst regardless of rlast; rlast mismatch (early or missing) sets the error flag.
REQ-022 SHALL set the sticky error flag on any accepted beat with rresp != 2'b00; data still forwarded.
REQ-023 SHALL, at burst end, add N*B to address, subtract N from remaining; remaining != 0 -> ADDR, else STATUS.
REQ-024 SHALL assert m_axis_tlast only on the final beat of the whole command, never at intermediate burst ends.
REQ-025 SHALL enter STATUS only after the final beat leaves the skid buffer; sts_valid held with sts_error until sts_ready, then IDLE.
REQ-026 SHALL have no combinational path from m_axis_tready to m_mm2s_axi_rready.

Reset
REQ-027 SHALL, on m_axi_aresetn low, immediately force state IDLE, clear the skid buffer, and drive cmd_ready=0, arvalid=0, rready=0, tvalid=0, tlast=0, sts_valid=0, sts_error=0, araddr=0, arlen=0; an in-flight burst is abandoned.
REQ-028 SHALL drive cmd_ready=1 from the first clock edge after reset deassertion.

Structure
REQ-029 SHALL place the FSM state enum, AXI burst/resp constants and 4 KB boundary constant in shared package dma_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module dma_skid_buffer (valid/ready, DATA_WIDTH+1 bits incl. tlast).

Verification (DATA_WIDTH=64, memory returns word index as data)
REQ-031 SHALL test cmd_addr=0x0, cmd_len=4 -> one AR araddr=0x0 arlen=3; stream 0,1,2,3, tlast on 3rd index; sts_error=0.
REQ-032 SHALL test cmd_addr=0x0, cmd_len=40 -> AR (0x000,15), (0x080,15), (0x100,7); 40 beats, single tlast.
REQ-033 SHALL test cmd_addr=0xFE0, cmd_len=8 -> AR (0xFE0,3), (0x1000,3).
REQ-034 SHALL test cmd_len=16 with tready toggling 1,0,0,1 -> 16 ordered beats, rready low when buffer full.
REQ-035 SHALL test rresp=2'b10 on beat 2 of cmd_len=4 -> all 4 beats forwarded, sts_error=1; cmd_len=0 -> no arvalid, sts_valid with sts_error=0.
REQ-036 SHALL test reset asserted mid-DATA -> all valids low same cycle; next command cmd_len=4 completes correctly.
